// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor helper and the parity build switch.
// Build option: define UART_CORE_PARITY_EN to add an even-parity bit after the data bits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

`ifdef UART_CORE_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Clocks per oversample tick; never below 1 so the tick can run every clock.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX FIFO + serialiser, RX deserialiser with holding register and error pulses.
// Build option: UART_CORE_PARITY_EN inserts an even-parity bit on both directions.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RsRx,
  output logic                 RsTx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  output logic                 tx_busy
);

  // Handshakes: a word moves when valid && ready are both high on a rising clk edge;
  // valid never waits on ready, and rx_valid holds its word until that transfer.

  localparam int SCW = $clog2(OVERSAMPLE * STOP_BITS);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(TX_FIFO_DEPTH);
  localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] BIT_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [BW-1:0]  IDX_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]    FULL      = (AW + 1)'(TX_FIFO_DEPTH);

  logic tick;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // ---------------- RX ----------------
  uart_state_e          rx_state;
  logic [1:0]           rx_sync;
  logic                 rx_line;
  logic [SCW-1:0]       rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bad;
  logic                 rx_commit;

  assign rx_line = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync    <= 2'b11;
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
      rx_commit  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], RsRx};
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_commit <= 1'b0;
      // A commit always wins over a same-cycle read; overrun only if the old word was not taken.
      if (rx_commit) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (tick) begin
        case (rx_state)
          ST_IDLE: begin
            if (!rx_line) begin
              rx_state   <= ST_START;
              rx_cnt     <= '0;
              rx_par_bad <= 1'b0;
            end
          end
          ST_START: begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt   <= '0;
              rx_idx   <= '0;
              rx_state <= rx_line ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == IDX_LAST) begin
                rx_state <= PARITY_EN ? ST_PARITY : ST_STOP;
              end else begin
                rx_idx <= rx_idx + 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt     <= '0;
              rx_par_bad <= rx_line ^ (^rx_shift);
              rx_state   <= ST_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            // Only the first stop bit is checked; returning to IDLE here allows back-to-back frames.
            if (rx_cnt == BIT_LAST) begin
              rx_cnt    <= '0;
              frame_err <= ~rx_line;
              rx_commit <= rx_line & ~rx_par_bad;
              rx_state  <= ST_IDLE;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: rx_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef UART_CORE_PARITY_EN
  logic rx_perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_perr_q <= 1'b0;
    end else begin
      rx_perr_q <= tick && (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && rx_par_bad;
    end
  end

  assign parity_err = rx_perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_cnt;
  logic                 tx_push, tx_pop;

  uart_state_e          tx_state;
  logic [SCW-1:0]       tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  assign tx_ready = (fifo_cnt != FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = tick && (fifo_cnt != '0) &&
                    ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_cnt == STOP_LAST)));
  assign tx_busy  = (tx_state != ST_IDLE) || (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      RsTx     <= 1'b1;
    end else if (tick) begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_par   <= ^fifo_mem[rd_ptr];
            tx_cnt   <= '0;
            RsTx     <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            RsTx     <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == IDX_LAST) begin
              RsTx     <= PARITY_EN ? tx_par : 1'b1;
              tx_state <= PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shift <= tx_shift >> 1;
              RsTx     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            RsTx     <= 1'b1;
            tx_state <= ST_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Chain straight into the next queued word so consecutive frames have no idle gap.
          if (tx_cnt == STOP_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_mem[rd_ptr];
              tx_par   <= ^fifo_mem[rd_ptr];
              RsTx     <= 1'b0;
              tx_state <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
